// File: rtl/rotate_right_seq_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rotate_right_seq_if : request/response bundle for the rotate_right_seq     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
interface rotate_right_seq_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [AMT_W-1:0] amount;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, data_in, amount,
    input  busy, done, result
  );

  modport slave (
    input  start, op, data_in, amount,
    output busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/rotate_right_seq.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rotate_right_seq : iterative ROR / SHR / SHRA unit, coarse + single steps  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module rotate_right_seq #(
  parameter int WIDTH    = 32,
  parameter int AMT_W    = 5,
  parameter int BIG_STEP = 4
) (
  input  wire logic          clock,
  input  wire logic          resetn,
  rotate_right_seq_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [AMT_W-1:0] c_big  = AMT_W'(BIG_STEP);
  localparam logic [1:0]       c_shr  = 2'b01;
  localparam logic [1:0]       c_shra = 2'b10;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_work, w_work_nxt;
  logic [AMT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]       r_op, w_op_nxt;
  logic             r_done, w_done_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;

  logic [BIG_STEP-1:0] w_fill_big;
  logic                w_fill_one;

  // Bits entering at the MSB: wrapped LSBs for ROR (and op 11), zeros, or sign copies.
  always_comb begin
    w_fill_big = r_work[BIG_STEP-1:0];
    w_fill_one = r_work[0];
    if (r_op == c_shr) begin
      w_fill_big = '0;
      w_fill_one = 1'b0;
    end else if (r_op == c_shra) begin
      w_fill_big = {BIG_STEP{r_work[WIDTH-1]}};
      w_fill_one = r_work[WIDTH-1];
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_work_nxt   = r_work;
    w_cnt_nxt    = r_cnt;
    w_op_nxt     = r_op;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_work_nxt  = bus.data_in;
          w_cnt_nxt   = bus.amount;
          w_op_nxt    = bus.op;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == '0) begin
          w_result_nxt = r_work;
          w_done_nxt   = 1'b1;
          w_state_nxt  = IDLE;
        end else if (r_cnt >= c_big) begin
          w_work_nxt = {w_fill_big, r_work[WIDTH-1:BIG_STEP]};
          w_cnt_nxt  = r_cnt - c_big;
        end else begin
          w_work_nxt = {w_fill_one, r_work[WIDTH-1:1]};
          w_cnt_nxt  = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= IDLE;
      r_work   <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_work   <= w_work_nxt;
      r_cnt    <= w_cnt_nxt;
      r_op     <= w_op_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign bus.busy   = (r_state == RUN);
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule
`default_nettype wire
